// File: rtl/sd_adc_pkg.sv
// sd_adc_pkg
// Shared material for the sigma-delta ADC array: default parameter values,
// the accumulator width function and the parameter legality check.
package sd_adc_pkg;

    localparam int DEF_CHANNELS   = 2;
    localparam int DEF_RESOLUTION = 8;
    localparam int DEF_WINDOW     = 110;
    localparam int DEF_DECIM      = 4;

    // Width needed to hold a window sum in the range 0..window.
    function automatic int acc_width(input int window);
        return $clog2(window + 1);
    endfunction

    // A PCM word must be able to hold the full-scale sum WINDOW without wrapping,
    // so 2**RESOLUTION has to exceed WINDOW.
    function automatic bit params_legal(input int channels, input int resolution,
                                        input int window, input int decim);
        bit fits;
        fits = (resolution >= 31) || ((1 << resolution) > window);
        return (channels >= 1) && (resolution >= 1) && (window >= 2) &&
               (decim >= 1) && fits;
    endfunction

endpackage

// File: rtl/sd_adc_channel.sv
// sd_adc_channel
// One sigma-delta channel: registers the comparator bit as modulator feedback,
// keeps a WINDOW-deep history of that feedback and a running boxcar sum.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   lvds      - comparator output for this channel
//   feedback  - registered modulator feedback
//   acc       - count of ones in the last WINDOW feedback samples
module sd_adc_channel
    import sd_adc_pkg::*;
#(
    parameter int WINDOW = DEF_WINDOW,
    parameter int ACC_W  = acc_width(DEF_WINDOW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lvds,
    output logic             feedback,
    output logic [ACC_W-1:0] acc
);

    // hist[WINDOW-1] is the oldest sample; it leaves the window as feedback enters.
    logic [WINDOW-1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            feedback <= 1'b0;
            hist     <= '0;
            acc      <= '0;
        end else begin
            feedback <= lvds;
            hist     <= {hist[WINDOW-2:0], feedback};
            acc      <= acc + ACC_W'(feedback) - ACC_W'(hist[WINDOW-1]);
        end
    end

endmodule

// File: rtl/sd_adc_array.sv
// sd_adc_array
// Array of CHANNELS sigma-delta channels sharing a priming (fill) counter and
// a decimation counter. Every DECIM enabled cycles after priming, all window
// sums are captured into the packed pcm output together with rail flags.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   en         - decimator enable (does not stall the accumulators)
//   lvds       - comparator outputs, one bit per channel
//   feedback   - registered modulator feedback, one bit per channel
//   pcm        - packed PCM words, channel c at [c*RESOLUTION +: RESOLUTION]
//   pcm_valid  - single-cycle strobe, common to all channels
//   clip       - per-channel rail flag, qualified by pcm_valid
// Output protocol: pcm_valid is a one-cycle strobe with no ready/back-pressure;
// pcm and clip are valid in that cycle and hold their values until the next one.
module sd_adc_array
    import sd_adc_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int RESOLUTION = DEF_RESOLUTION,
    parameter int WINDOW     = DEF_WINDOW,
    parameter int DECIM      = DEF_DECIM
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [CHANNELS-1:0]            lvds,
    output logic [CHANNELS-1:0]            feedback,
    output logic [CHANNELS*RESOLUTION-1:0] pcm,
    output logic                           pcm_valid,
    output logic [CHANNELS-1:0]            clip
);

    localparam int ACC_W  = acc_width(WINDOW);
    localparam int FILL_W = $clog2(WINDOW + 1);
    localparam int CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    if (!params_legal(CHANNELS, RESOLUTION, WINDOW, DECIM)) begin : g_bad_params
        $error("sd_adc_array: illegal parameters (need CHANNELS>=1, WINDOW>=2, DECIM>=1, 2**RESOLUTION > WINDOW)");
    end

    logic [ACC_W-1:0]  acc [CHANNELS];
    logic [FILL_W-1:0] fill;
    logic [CNT_W-1:0]  dcnt;
    logic              primed;
    logic              advance;
    logic              wrap;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        sd_adc_channel #(
            .WINDOW (WINDOW),
            .ACC_W  (ACC_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .lvds     (lvds[g]),
            .feedback (feedback[g]),
            .acc      (acc[g])
        );
    end

    // Primed once a full window of post-reset samples has been seen.
    assign primed  = (fill == FILL_W'(WINDOW));
    assign advance = en && primed;
    assign wrap    = advance && (dcnt == CNT_W'(DECIM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            fill      <= '0;
            dcnt      <= '0;
            pcm       <= '0;
            pcm_valid <= 1'b0;
            clip      <= '0;
        end else begin
            if (!primed) begin
                fill <= fill + 1'b1;
            end
            if (advance) begin
                dcnt <= wrap ? '0 : dcnt + 1'b1;
            end
            pcm_valid <= wrap;
            if (wrap) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    pcm[c*RESOLUTION +: RESOLUTION] <= RESOLUTION'(acc[c]);
                    clip[c] <= (acc[c] == '0) || (acc[c] == ACC_W'(WINDOW));
                end
            end
        end
    end

endmodule

// File: doc/sd_adc_array.md
SD_ADC_ARRAY -- requirements
Module: sd_adc_array

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent sigma-delta channels, at least 1.
REQ-002 Parameter RESOLUTION, default 8: width of each PCM word.
REQ-003 Parameter WINDOW, default 110: boxcar length in feedback samples, at least 2.
REQ-004 Parameter DECIM, default 4: output decimation ratio in clk cycles, at least 1.
REQ-005 clk  input  1: single clock; all state updates on its rising edge.
REQ-006 rst  input  1: reset, synchronous and active-high.
REQ-007 en  input  1: decimator enable.
REQ-008 lvds  input  CHANNELS: comparator outputs, one bit per channel.
REQ-009 feedback  output  CHANNELS: registered modulator feedback, one bit per channel.
REQ-010 pcm  output  CHANNELS*RESOLUTION: packed PCM words; channel c occupies bits [c*RESOLUTION +: RESOLUTION].
REQ-011 pcm_valid  output  1: single-cycle strobe, common to all channels.
REQ-012 clip  output  CHANNELS: rail flag per channel, qualified by pcm_valid.

Function
REQ-013 Each cycle, feedback[c] SHALL take the value of lvds[c]; this tracking is independent of en.
REQ-014 Each channel SHALL keep a WINDOW-deep shift history of feedback[c] and a running sum acc.
- acc <= acc + feedback[c] - oldest history bit, every cycle, independent of en.
- acc therefore always equals the count of ones in the last WINDOW feedback samples, range 0..WINDOW.
REQ-015 A parameter with 2**RESOLUTION <= WINDOW SHALL be rejected at elaboration; acc SHALL never wrap.
REQ-016 A shared fill counter SHALL count cycles after reset, saturating at WINDOW.
- Once it reaches WINDOW, the block is primed and stays primed until the next rst.
REQ-017 A decimation counter SHALL run 0..DECIM-1 and wrap.
- It advances only while en=1 and the block is primed.
- It holds its value while en=0.
REQ-018 When the counter equals DECIM-1 and it advances, the following SHALL happen on the next cycle:
- pcm[c] <= acc zero-extended to RESOLUTION, for every channel simultaneously.
- clip[c] <= 1 if acc == 0 or acc == WINDOW, else 0.
- pcm_valid <= 1 for exactly one cycle.
REQ-019 pcm and clip SHALL hold their values between strobes; pcm_valid SHALL be 0 at all other times.
REQ-020 With en held at 1 after priming, strobes SHALL occur exactly every DECIM cycles; DECIM=1 SHALL give a strobe every cycle.
REQ-021 Deasserting en SHALL suppress strobes with no loss of accumulator history.
- On reassertion, counting SHALL resume from the held counter value.
REQ-022 If en falls in the same cycle the counter would wrap, no strobe SHALL occur for that cycle.

Reset
REQ-023 The following SHALL be 0 one cycle after rst is sampled high: feedback, the history registers, acc, the fill counter, the decimation counter, pcm, pcm_valid and clip.
REQ-024 rst asserted mid-operation SHALL abort any pending strobe and restart priming; rst takes precedence over en.

Structure
REQ-025 Package sd_adc_pkg SHALL hold the shared material:
- the acc width function clog2(WINDOW+1);
- the parameter-legality check;
- default parameter constants.
REQ-026 Sub-module sd_adc_channel (feedback register, history, acc) SHALL be instantiated CHANNELS times by generate.
- The fill counter, decimation counter and output registers SHALL live in sd_adc_array.

Verification (CHANNELS=2, RESOLUTION=8, WINDOW=110, DECIM=4 unless stated)
REQ-027 Hold rst 3 cycles, then lvds=2'b11 constant -> no pcm_valid in the first 110 cycles after reset; then strobes every 4 cycles with pcm = {8'd110, 8'd110} and clip = 2'b11.
REQ-028 lvds[0] alternating 1,0 and lvds[1]=0 -> after priming, channel 0 = 55 with clip[0]=0; channel 1 = 0 with clip[1]=1.
REQ-029 With a primed block, drop en for 20 cycles -> no strobes and pcm unchanged; after en returns, the next strobe arrives within 4 cycles and carries the current window sum.
REQ-030 Assert rst for 1 cycle mid-stream -> all outputs 0 on the next cycle; the next strobe comes no earlier than 110 cycles later.
REQ-031 DECIM=1 with lvds=1 constant -> pcm_valid continuously high after priming; a step to 0 ramps pcm down by exactly 1 per cycle to 0.
REQ-032 Elaborate with RESOLUTION=6 and WINDOW=110 -> elaboration fails.
